// File: rtl/ad7606_serial_rx_param.sv
// ad7606_serial_rx_param: serial-mode AD7606 capture engine driving RESET/CONVST/CS/SCLK
// and presenting one packed frame per conversion with a single-cycle valid strobe.
module ad7606_serial_rx_param #(
  parameter int CH_NUM       = 8,
  parameter int BITS         = 16,
  parameter int DOUT_LINES   = 2,
  parameter int SCLK_DIV     = 1,
  parameter int CNV_PULSE    = 2,
  parameter int USE_BUSY     = 1,
  parameter int CONV_WAIT    = 60,
  parameter int BUSY_TIMEOUT = 1023,
  parameter int RST_CYCLES   = 4
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   conv_start,
  output logic                   busy_o,
  output logic                   frame_valid,
  output logic [CH_NUM*BITS-1:0] frame_data,
  output logic                   timeout_err,
  output logic                   yad_rst,
  output logic                   yad_cvn,
  output logic                   yad_cs,
  output logic                   yad_ck,
  input  logic                   yad_busy,
  input  logic                   yad_sa,
  input  logic                   yad_sb
);
  localparam int FW = CH_NUM * BITS;
  localparam int LB = FW / DOUT_LINES;
  localparam int M0 = RST_CYCLES > CNV_PULSE ? RST_CYCLES : CNV_PULSE;
  localparam int M1 = CONV_WAIT > BUSY_TIMEOUT ? CONV_WAIT : BUSY_TIMEOUT;
  localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);
  localparam int TW = $clog2(2 * LB + 1);
  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_CONV  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    div;
  logic [TW-1:0] tog;
  logic [LB-1:0] sh_a, sh_b;
  logic          busy_m, busy_s;
  logic [FW-1:0] pack;
  logic          wait_done, wait_abort;

  // the first two WAIT cycles are blind: BUSY needs time to rise through the synchroniser
  assign wait_done  = USE_BUSY != 0 ? (cnt >= CW'(2) && !busy_s) : (cnt == CW'(CONV_WAIT - 1));
  assign wait_abort = USE_BUSY != 0 && cnt == CW'(BUSY_TIMEOUT - 1);

  if (DOUT_LINES == 2) begin : g_two
    assign pack = {sh_a, sh_b};
  end else begin : g_one
    assign pack = sh_a;
  end

  always_ff @(posedge clkin or negedge rst_n)
    if (!rst_n) begin
      state       <= ST_RST;
      cnt         <= '0;
      div         <= '0;
      tog         <= '0;
      sh_a        <= '0;
      sh_b        <= '0;
      busy_m      <= 1'b0;
      busy_s      <= 1'b0;
      yad_rst     <= 1'b1;
      yad_cvn     <= 1'b0;
      yad_cs      <= 1'b1;
      yad_ck      <= 1'b1;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
      frame_data  <= '0;
      busy_o      <= 1'b1;
    end else begin
      busy_m      <= yad_busy;
      busy_s      <= busy_m;
      frame_valid <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ST_RST:
          if (cnt == CW'(RST_CYCLES - 1)) begin
            yad_rst <= 1'b0;
            busy_o  <= 1'b0;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else cnt <= cnt + CW'(1);
        ST_IDLE: begin
          busy_o <= conv_start;
          if (conv_start) begin
            yad_cvn <= 1'b1;
            cnt     <= '0;
            state   <= ST_CONV;
          end
        end
        ST_CONV:
          if (cnt == CW'(CNV_PULSE - 1)) begin
            yad_cvn <= 1'b0;
            cnt     <= '0;
            state   <= ST_WAIT;
          end else cnt <= cnt + CW'(1);
        ST_WAIT:
          if (wait_done) begin
            yad_cs <= 1'b0;
            cnt    <= '0;
            div    <= '0;
            tog    <= '0;
            state  <= ST_SHIFT;
          end else if (wait_abort) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else cnt <= cnt + CW'(1);
        ST_SHIFT:
          if (div != 4'(SCLK_DIV - 1)) div <= div + 4'd1;
          else begin
            div <= '0;
            if (tog == TW'(2 * LB)) begin
              yad_cs <= 1'b1;
              state  <= ST_DONE;
            end else begin
              yad_ck <= ~yad_ck;
              tog    <= tog + TW'(1);
              // data is taken at the end of each low phase, as SCLK is driven back high
              if (!yad_ck) begin
                sh_a <= {sh_a[LB-2:0], yad_sa};
                sh_b <= {sh_b[LB-2:0], yad_sb};
              end
            end
          end
        ST_DONE: begin
          frame_data  <= pack;
          frame_valid <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_RST;
      endcase
    end
endmodule

// File: tb/tb_ad7606_serial_rx_param.sv
// tb_ad7606_serial_rx_param: three configurations of the capture engine against behavioural
// ADC models (serialised channel words, BUSY pulse) with table-driven and hand-written checks.
module tb_ad7606_serial_rx_param;
  typedef struct {
    logic [17:0]  ch [8];
    logic [143:0] exp;
  } vec_t;

  logic clkin = 1'b0, rst_n = 1'b1;
  always #5 clkin = ~clkin;

  logic st0 = 0, st1 = 0, st2 = 0, busy2 = 0, stuck = 0;
  logic sa0 = 0, sb0 = 0, sa1 = 0, sa2 = 0, sb2 = 0;
  logic bo0, fv0, te0, rst0, cvn0, cs0, ck0;
  logic bo1, fv1, te1, rst1, cvn1, cs1, ck1;
  logic bo2, fv2, te2, rst2, cvn2, cs2, ck2;
  logic [127:0] fd0, fd2;
  logic [143:0] fd1;
  logic [63:0]  la0 = 0, lb0 = 0, la2 = 0, lb2 = 0;
  logic [143:0] la1 = 0;
  int f0 = 0, f1 = 0, f2 = 0, b0 = 0, b1 = 0, b2 = 0;
  int errors = 0, checks = 0;
  vec_t v0 [4];
  vec_t v1 [2];
  vec_t v2 [2];

  ad7606_serial_rx_param #(.USE_BUSY(0), .CONV_WAIT(60)) u0 (
    .clkin(clkin), .rst_n(rst_n), .conv_start(st0), .busy_o(bo0), .frame_valid(fv0),
    .frame_data(fd0), .timeout_err(te0), .yad_rst(rst0), .yad_cvn(cvn0), .yad_cs(cs0),
    .yad_ck(ck0), .yad_busy(1'b0), .yad_sa(sa0), .yad_sb(sb0));

  ad7606_serial_rx_param #(.BITS(18), .DOUT_LINES(1), .SCLK_DIV(2), .USE_BUSY(0)) u1 (
    .clkin(clkin), .rst_n(rst_n), .conv_start(st1), .busy_o(bo1), .frame_valid(fv1),
    .frame_data(fd1), .timeout_err(te1), .yad_rst(rst1), .yad_cvn(cvn1), .yad_cs(cs1),
    .yad_ck(ck1), .yad_busy(1'b0), .yad_sa(sa1), .yad_sb(1'b1));

  ad7606_serial_rx_param #(.USE_BUSY(1), .BUSY_TIMEOUT(100)) u2 (
    .clkin(clkin), .rst_n(rst_n), .conv_start(st2), .busy_o(bo2), .frame_valid(fv2),
    .frame_data(fd2), .timeout_err(te2), .yad_rst(rst2), .yad_cvn(cvn2), .yad_cs(cs2),
    .yad_ck(ck2), .yad_busy(busy2), .yad_sa(sa2), .yad_sb(sb2));

  // ADC models: the k-th SCLK fall of a frame presents bit k (MSB first) of each line word
  always @(negedge ck0) begin : m0
    int k;
    f0++;
    k = f0 - b0;
    if (k >= 1 && k <= 64) begin sa0 = la0[64-k]; sb0 = lb0[64-k]; end
  end
  always @(negedge ck1) begin : m1
    int k;
    f1++;
    k = f1 - b1;
    if (k >= 1 && k <= 144) sa1 = la1[144-k];
  end
  always @(negedge ck2) begin : m2
    int k;
    f2++;
    k = f2 - b2;
    if (k >= 1 && k <= 64) begin sa2 = la2[64-k]; sb2 = lb2[64-k]; end
  end

  // BUSY: high for 50 cycles after CONVST (or forever when stuck), then a glitch once CS is low
  always @(posedge cvn2) begin
    busy2 = 1'b1;
    if (!stuck) begin
      repeat (50) @(posedge clkin);
      @(negedge clkin) busy2 = 1'b0;
      @(negedge cs2);
      repeat (5) @(negedge clkin);
      busy2 = 1'b1;
      repeat (3) @(negedge clkin);
      busy2 = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [143:0] cat(input logic [17:0] ch [8], input int bits);
    logic [143:0] r = '0;
    for (int i = 0; i < 8; i++) r = (r << bits) | 144'(ch[i]);
    return r;
  endfunction

  task automatic load(input int u, input logic [17:0] ch [8]);
    logic [63:0] a = '0, b = '0;
    logic [143:0] s = '0;
    for (int i = 0; i < 8; i++) begin
      s = {s[125:0], ch[i]};
      if (i < 4) a = {a[47:0], ch[i][15:0]};
      else b = {b[47:0], ch[i][15:0]};
    end
    if (u == 0) begin la0 = a; lb0 = b; end
    else if (u == 1) la1 = s;
    else begin la2 = a; lb2 = b; end
  endtask

  function automatic logic fv_of(int u);
    return u == 0 ? fv0 : u == 1 ? fv1 : fv2;
  endfunction
  function automatic logic bo_of(int u);
    return u == 0 ? bo0 : u == 1 ? bo1 : bo2;
  endfunction
  function automatic logic cvn_of(int u);
    return u == 0 ? cvn0 : u == 1 ? cvn1 : cvn2;
  endfunction
  function automatic logic [143:0] fd_of(int u);
    return u == 0 ? 144'(fd0) : u == 1 ? fd1 : 144'(fd2);
  endfunction
  function automatic int f_of(int u);
    return u == 0 ? f0 : u == 1 ? f1 : f2;
  endfunction

  task automatic start(input int u, input logic v);
    if (u == 0) st0 = v;
    else if (u == 1) st1 = v;
    else st2 = v;
  endtask

  // one conversion: latency counts the conv_start sample cycle as 1
  task automatic run(input int u, input logic [143:0] exp, input int falls, input int lat_exp,
                     input int per, input string nm);
    int lat, fb, ta, tb, tbz, tcs;
    logic sb;
    fb = f_of(u);
    if (u == 0) b0 = fb; else if (u == 1) b1 = fb; else b2 = fb;
    ta = -1; tb = -1; tbz = -1; tcs = -1; sb = 0;
    start(u, 1'b1);
    tick;
    start(u, 1'b0);
    lat = 1;
    chk({nm, "_cvn_rise"}, cvn_of(u), 1);
    while (!fv_of(u) && lat < 1500) begin
      tick;
      lat++;
      if (f_of(u) - fb == 1 && ta < 0) ta = lat;
      if (f_of(u) - fb == 2 && tb < 0) tb = lat;
      if (u == 2) begin
        if (busy2) sb = 1;
        else if (sb && tbz < 0) tbz = lat;
        if (!cs2 && tcs < 0) tcs = lat;
      end
    end
    chk({nm, "_valid"}, fv_of(u), 1);
    if (lat_exp > 0) chk({nm, "_latency"}, lat, lat_exp);
    chk({nm, "_frame"}, fd_of(u), exp);
    chk({nm, "_falls"}, f_of(u) - fb, falls);
    chk({nm, "_period"}, tb - ta, per);
    chk({nm, "_busy_at_valid"}, bo_of(u), 1);
    if (u == 2) chk({nm, "_busy_to_cs"}, tcs - tbz, 2);
    tick;
    chk({nm, "_valid_1cyc"}, fv_of(u), 0);
    chk({nm, "_busy_after"}, bo_of(u), 0);
  endtask

  initial begin
    int n, m;
    logic seen, csl, fvs;
    logic [127:0] prev;
    for (int i = 0; i < 8; i++) begin
      v0[0].ch[i] = 18'(16'h1111 * (i + 1));
      v0[1].ch[i] = (i % 2 == 0) ? 18'h0FFFF : 18'h0;
      v0[2].ch[i] = 18'($urandom_range(0, 65535));
      v0[3].ch[i] = 18'($urandom_range(0, 65535));
      v1[0].ch[i] = 18'(18'h3FFF0 + i + 1);
      v1[1].ch[i] = 18'($urandom_range(0, 262143));
      v2[0].ch[i] = 18'($urandom_range(0, 65535));
      v2[1].ch[i] = 18'($urandom_range(0, 65535));
    end
    v0[0].exp = 144'h1111_2222_3333_4444_5555_6666_7777_8888;
    v0[1].exp = 144'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    v0[2].exp = cat(v0[2].ch, 16);
    v0[3].exp = cat(v0[3].ch, 16);
    v1[0].exp = cat(v1[0].ch, 18);
    v1[1].exp = cat(v1[1].ch, 18);
    v2[0].exp = cat(v2[0].ch, 16);
    v2[1].exp = cat(v2[1].ch, 16);

    #2 rst_n = 1'b0;
    repeat (3) tick;
    chk("reset_ctl_u0", {rst0, cvn0, cs0, ck0, fv0, te0, bo0}, 7'b1011001);
    chk("reset_ctl_u1", {rst1, cvn1, cs1, ck1, fv1, te1, bo1}, 7'b1011001);
    chk("reset_ctl_u2", {rst2, cvn2, cs2, ck2, fv2, te2, bo2}, 7'b1011001);
    chk("reset_fd", {fd0 | fd2, fd1}, 0);
    rst_n = 1'b1;
    st0 = 1'b1;
    n = 0;
    seen = 0;
    while (rst0 && n < 20) begin
      tick;
      n++;
      if (n == 2) st0 = 1'b0;
      seen |= cvn0;
    end
    chk("adc_rst_len", n, 4);
    chk("rst_end_ctl", {cs0, ck0, cvn0, bo0}, 4'b1100);
    repeat (3) begin tick; seen |= cvn0; end
    chk("rst_no_cvn", seen, 0);

    for (int i = 0; i < 4; i++) begin
      load(0, v0[i].ch);
      run(0, v0[i].exp, 64, 193, 2, $sformatf("u0_v%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      load(1, v1[i].ch);
      run(1, v1[i].exp, 144, 0, 4, $sformatf("u1_v%0d", i));
    end
    load(2, v2[0].ch);
    run(2, v2[0].exp, 64, 0, 2, "u2_busy");

    stuck = 1'b1;
    prev = fd2;
    st2 = 1'b1;
    tick;
    st2 = 1'b0;
    m = 0;
    while (cvn2 && m < 10) begin tick; m++; end
    n = 0; csl = 0; fvs = 0;
    while (!te2 && n < 300) begin
      tick;
      n++;
      csl |= !cs2;
      fvs |= fv2;
    end
    chk("timeout_cycle", n, 100);
    tick;
    fvs |= fv2;
    chk("timeout_1cyc", te2, 0);
    chk("timeout_busy_low", bo2, 0);
    chk("timeout_no_cs", csl, 0);
    chk("timeout_no_valid", fvs, 0);
    chk("timeout_fd_held", fd2, prev);
    stuck = 1'b0;
    load(2, v2[1].ch);
    run(2, v2[1].exp, 64, 0, 2, "u2_recover");

    load(0, v0[2].ch);
    b0 = f0;
    st0 = 1'b1;
    tick;
    st0 = 1'b0;
    n = 0;
    while (!(f0 - b0 == 10 && ck0) && n < 400) begin tick; n++; end
    chk("mid_reach", f0 - b0, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_ctl", {rst0, cvn0, cs0, ck0, fv0, bo0}, 6'b101101);
    chk("mid_reset_fd", fd0, 0);
    tick;
    tick;
    rst_n = 1'b1;
    n = 0;
    while (rst0 && n < 20) begin tick; n++; end
    load(0, v0[3].ch);
    run(0, v0[3].exp, 64, 193, 2, "u0_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ad7606_serial_rx_param.md
Name: ad7606_serial_rx_param

Overview:
- Parametrised serial-mode AD7606-family capture engine, successor of the fixed 8x16-bit, two-line reader.
- Generates CONVST, CS and a registered, divided SCLK.
- Waits for conversion end using either the BUSY pin (with timeout) or a fixed delay.
- Shifts in 1 or 2 DOUT lines and presents one packed frame with a single-cycle valid strobe to the downstream FIFO/DMA logic.
- Also drives the ADC RESET pulse after system reset.

Parameters:
- CH_NUM, 8: channels per frame; must be even when DOUT_LINES=2.
- BITS, 16: bits per channel (16 or 18).
- DOUT_LINES, 2: serial data lines used (1 = yad_sa only, 2 = yad_sa and yad_sb).
- SCLK_DIV, 1: SCLK half-period in clkin cycles (1..15).
- CNV_PULSE, 2: yad_cvn high time in clkin cycles (>=1).
- USE_BUSY, 1: 1 = wait on yad_busy; 0 = fixed wait of CONV_WAIT cycles.
- CONV_WAIT, 60: fixed conversion wait in clkin cycles (used when USE_BUSY=0).
- BUSY_TIMEOUT, 1023: maximum cycles in WAIT before abort (used when USE_BUSY=1).
- RST_CYCLES, 4: yad_rst high time in clkin cycles after rst_n release.

Ports:
- clkin, in, 1: main clock (10-50 MHz).
- rst_n, in, 1: asynchronous active-low reset.
- conv_start, in, 1: start request; sampled in IDLE only.
- busy_o, out, 1: high from leaving IDLE until frame_valid or abort; also high during RST.
- frame_valid, out, 1: one-cycle strobe, frame_data is new.
- frame_data, out, CH_NUM*BITS: channel 1 in MSBs through channel CH_NUM in LSBs; held until next frame.
- timeout_err, out, 1: one-cycle strobe on BUSY timeout.
- yad_rst, out, 1: ADC RESET, active high.
- yad_cvn, out, 1: ADC CONVST A/B, tied together.
- yad_cs, out, 1: ADC CS, active low.
- yad_ck, out, 1: ADC SCLK, idles high, registered (never gated from clkin).
- yad_busy, in, 1: ADC BUSY; asynchronous, double-flop synchronised internally.
- yad_sa, in, 1: DOUTA.
- yad_sb, in, 1: DOUTB; ignored when DOUT_LINES=1.

Behaviour:
- Reset values (rst_n low, all outputs registered):
  - state = RST; yad_rst = 1; yad_cvn = 0; yad_cs = 1; yad_ck = 1.
  - frame_valid = 0; timeout_err = 0; frame_data = 0; busy_o = 1; all counters = 0.
- RST: hold yad_rst = 1 for RST_CYCLES cycles after rst_n rises, then yad_rst = 0 and go to IDLE. conv_start is ignored during RST.
- IDLE: busy_o = 0. If conv_start = 1, go to CONV next cycle with yad_cvn = 1.
  - conv_start is level-sampled, so a held-high conv_start retriggers immediately after each frame.
- CONV: yad_cvn stays high exactly CNV_PULSE cycles, then drops to 0 and the FSM enters WAIT.
- WAIT, USE_BUSY = 1:
  - Ignore synced BUSY for the first 2 cycles (BUSY rise latency).
  - Then leave WAIT on the first cycle synced BUSY = 0.
  - If WAIT reaches BUSY_TIMEOUT cycles: pulse timeout_err for one cycle, go to IDLE, leave yad_cs = 1, no frame_valid, frame_data unchanged.
- WAIT, USE_BUSY = 0: leave WAIT after exactly CONV_WAIT cycles.
- Leaving WAIT: yad_cs goes 0 and the FSM enters SHIFT.
- SHIFT:
  - LINE_BITS = CH_NUM*BITS/DOUT_LINES.
  - yad_ck toggles every SCLK_DIV cycles, starting with a falling edge SCLK_DIV cycles after yad_cs falls.
  - yad_sa/yad_sb are sampled in the clkin cycle in which yad_ck is driven high again (end of low phase), MSB first.
  - Exactly LINE_BITS falling edges are produced. After the last rising edge, yad_cs = 1 and yad_ck stays 1.
  - Total SHIFT length = SCLK_DIV*(2*LINE_BITS+1) cycles.
- Packing:
  - DOUT_LINES = 2: line A carries channels 1..CH_NUM/2, line B carries CH_NUM/2+1..CH_NUM; frame_data = {shiftA, shiftB}.
  - DOUT_LINES = 1: line A carries all channels in order.
- DONE (one cycle):
  - frame_data loaded from the shift registers; frame_valid = 1 the same cycle.
  - busy_o = 0 from the next cycle; return to IDLE.
- Latency, defaults with USE_BUSY = 0 and CONV_WAIT = 60:
  - conv_start sampled → yad_cvn rises next cycle.
  - frame_valid = 1 + 2 + 60 + 129 + 1 cycles after the conv_start sample.
- Boundary conditions:
  - Asynchronous reset mid-frame: all outputs return to their reset values immediately; any partial frame is discarded.
  - timeout_err and frame_valid are mutually exclusive per conversion.
  - A BUSY glitch after CS has fallen is ignored.

Test Plan:
- Reset and ADC reset: release rst_n → yad_rst high exactly 4 cycles; yad_cs = 1, yad_ck = 1, yad_cvn = 0, busy_o = 0 at the end of RST; conv_start pulses during RST produce no yad_cvn.
- Default frame, fixed wait: USE_BUSY = 0; model DOUTA = 0x1111,0x2222,0x3333,0x4444 and DOUTB = 0x5555..0x8888 → frame_data = 0x1111222233334444555566667777888 8 (0x11112222333344445555666677778888); exactly 64 SCLK falls; frame_valid one cycle at 193 cycles after conv_start.
- Single line, 18-bit, SCLK_DIV = 2: CH_NUM = 8, BITS = 18, DOUT_LINES = 1, channel n = 0x3FFF0+n → frame_data matches; 144 SCLK falls; SCLK period 4 cycles.
- BUSY handshake: BUSY model high for 50 cycles after CONVST → CS falls 1 cycle after synced BUSY low; frame correct; busy_o low after frame_valid.
- BUSY stuck high: BUSY_TIMEOUT = 100, BUSY never falls → timeout_err pulse at WAIT cycle 100; yad_cs never low; frame_data unchanged; next conv_start with a healthy BUSY yields a valid frame.
- Reset mid-SHIFT: assert rst_n low after 20 SCLK edges → yad_cs = 1, yad_ck = 1 immediately, frame_data = 0, no frame_valid; post-reset frame is correct.
